// File: rtl/mem_op_pkg.sv
// Shared constants for the load/store control-step sequencer: state encoding,
// opcodes, wait limit and the bit map of the packed control-strobe bus.
package mem_op_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] LD_OP  = 5'b00000;
  localparam logic [OPCODE_W-1:0] LDI_OP = 5'b00001;
  localparam logic [OPCODE_W-1:0] ST_OP  = 5'b00010;

  localparam logic [3:0] WAIT_MAX = 4'd15;

  // Encoding doubles as the debug step code.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd7,
    S_T1   = 4'd8,
    S_T2   = 4'd9,
    S_T3   = 4'd10,
    S_T4   = 4'd11,
    S_T5   = 4'd12,
    S_T6   = 4'd13,
    S_T7   = 4'd14,
    S_DONE = 4'd15
  } state_e;

  localparam int CTRL_PCOUT   = 0;
  localparam int CTRL_MARIN   = 1;
  localparam int CTRL_INCPC   = 2;
  localparam int CTRL_ZIN     = 3;
  localparam int CTRL_ZLOWOUT = 4;
  localparam int CTRL_PCIN    = 5;
  localparam int CTRL_READ    = 6;
  localparam int CTRL_MDRIN   = 7;
  localparam int CTRL_MDROUT  = 8;
  localparam int CTRL_IRIN    = 9;
  localparam int CTRL_GRB     = 10;
  localparam int CTRL_BAOUT   = 11;
  localparam int CTRL_YIN     = 12;
  localparam int CTRL_COUT    = 13;
  localparam int CTRL_ADD     = 14;
  localparam int CTRL_GRA     = 15;
  localparam int CTRL_RIN     = 16;
  localparam int CTRL_ROUT    = 17;
  localparam int CTRL_WRITE   = 18;
  localparam int CTRL_W       = 19;

endpackage

// File: rtl/mem_op_decode.sv
// Pure combinational step decode: (state, opcode) -> control strobes, opcode
// legality and whether the current step waits on the memory handshake.
module mem_op_decode
  import mem_op_pkg::*;
(
  input  state_e              state_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic                is_legal_o,
  output logic                is_wait_o
);

  logic is_ld, is_ldi, is_st;

  assign is_ld  = (opcode_i == LD_OP);
  assign is_ldi = (opcode_i == LDI_OP);
  assign is_st  = (opcode_i == ST_OP);

  always_comb begin
    ctrl_o     = '0;
    is_wait_o  = 1'b0;
    is_legal_o = is_ld | is_ldi | is_st;
    case (state_i)
      S_T0: begin
        ctrl_o[CTRL_PCOUT] = 1'b1;
        ctrl_o[CTRL_MARIN] = 1'b1;
        ctrl_o[CTRL_INCPC] = 1'b1;
        ctrl_o[CTRL_ZIN]   = 1'b1;
      end
      S_T1: begin
        ctrl_o[CTRL_ZLOWOUT] = 1'b1;
        ctrl_o[CTRL_PCIN]    = 1'b1;
        ctrl_o[CTRL_READ]    = 1'b1;
        ctrl_o[CTRL_MDRIN]   = 1'b1;
        is_wait_o            = 1'b1;
      end
      S_T2: begin
        ctrl_o[CTRL_MDROUT] = 1'b1;
        ctrl_o[CTRL_IRIN]   = 1'b1;
      end
      S_T3: begin
        // An illegal opcode leaves the strobes quiet so the datapath is untouched.
        if (is_legal_o) begin
          ctrl_o[CTRL_GRB]   = 1'b1;
          ctrl_o[CTRL_BAOUT] = 1'b1;
          ctrl_o[CTRL_YIN]   = 1'b1;
        end
      end
      S_T4: begin
        ctrl_o[CTRL_COUT] = 1'b1;
        ctrl_o[CTRL_ADD]  = 1'b1;
        ctrl_o[CTRL_ZIN]  = 1'b1;
      end
      S_T5: begin
        if (is_ld || is_st) begin
          ctrl_o[CTRL_ZLOWOUT] = 1'b1;
          ctrl_o[CTRL_MARIN]   = 1'b1;
        end else if (is_ldi) begin
          ctrl_o[CTRL_ZLOWOUT] = 1'b1;
          ctrl_o[CTRL_GRA]     = 1'b1;
          ctrl_o[CTRL_RIN]     = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          ctrl_o[CTRL_READ]  = 1'b1;
          ctrl_o[CTRL_MDRIN] = 1'b1;
          is_wait_o          = 1'b1;
        end else if (is_st) begin
          ctrl_o[CTRL_GRA]   = 1'b1;
          ctrl_o[CTRL_ROUT]  = 1'b1;
          ctrl_o[CTRL_MDRIN] = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          ctrl_o[CTRL_MDROUT] = 1'b1;
          ctrl_o[CTRL_GRA]    = 1'b1;
          ctrl_o[CTRL_RIN]    = 1'b1;
        end else if (is_st) begin
          ctrl_o[CTRL_WRITE] = 1'b1;
          is_wait_o          = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_op_sequencer.sv
// Control-step FSM for ld/ldi/st with memory wait handshake and done/illegal
// status. Optional wait watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_op_sequencer
  import mem_op_pkg::*;
(
  input  logic                Clock,
  input  logic                Clear,
  input  logic                start,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                mem_ready,
  output logic [CTRL_W-1:0]   ctrl,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                timeout,
  output logic [3:0]          step
);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   dec_ctrl;
  logic                is_legal;
  logic                is_wait;
  logic                timeout_hit;

  mem_op_decode u_decode (
    .state_i    (state_q),
    .opcode_i   (ir_opcode),
    .ctrl_o     (dec_ctrl),
    .is_legal_o (is_legal),
    .is_wait_o  (is_wait)
  );

`ifdef MEM_TIMEOUT_EN
  // Counts consecutive not-ready cycles; restarts whenever the state moves on.
  logic [3:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (is_wait && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign timeout_hit = is_wait && (wait_cnt_q == WAIT_MAX);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = is_legal ? S_T4 : S_IDLE;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = (ir_opcode == LDI_OP) ? S_DONE : S_T6;
      S_T6:    state_d = S_T7;
      S_T7:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Memory handshake overrides the step progression in wait steps.
    if (timeout_hit) begin
      state_d = S_IDLE;
    end else if (is_wait && !mem_ready) begin
      state_d = state_q;
    end
  end

  always_comb begin
    ctrl    = timeout_hit ? '0 : dec_ctrl;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    illegal = (state_q == S_T3) && !is_legal;
    timeout = timeout_hit;
    step    = state_q;
  end

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Table-driven bench for mem_op_sequencer: per-cycle vectors for ld/st/ldi and
// illegal opcodes, plus hand sequences for Clear mid-wait and unbounded waits.
module tb_mem_op_sequencer;
  import mem_op_pkg::*;

  localparam int OBS_W = 4 + CTRL_W + 4;
  localparam logic [3:0] F_B = 4'b1000;
  localparam logic [3:0] F_D = 4'b0100;
  localparam logic [3:0] F_I = 4'b0010;
  localparam logic [3:0] F_T = 4'b0001;
  localparam logic [4:0] BAD_OP = 5'b11111;

  logic                Clock = 1'b0;
  logic                Clear;
  logic                start;
  logic [OPCODE_W-1:0] ir_opcode;
  logic                mem_ready;
  logic [CTRL_W-1:0]   ctrl;
  logic                busy, done, illegal, timeout;
  logic [3:0]          step;

  mem_op_sequencer dut (
    .Clock     (Clock),
    .Clear     (Clear),
    .start     (start),
    .ir_opcode (ir_opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal),
    .timeout   (timeout),
    .step      (step)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  typedef struct {
    logic              start;
    logic              mr;
    logic [4:0]        op;
    logic [3:0]        e_step;
    logic [CTRL_W-1:0] e_ctrl;
    logic [3:0]        e_flags;
  } vec_t;

  vec_t              tbl[$];
  logic [OBS_W-1:0]  exp_q[$];
  int                checks = 0;
  int                failures = 0;

  logic [CTRL_W-1:0] C_T0, C_T1, C_T2, C_T3, C_T4, C_T5LS, C_T5I;
  logic [CTRL_W-1:0] C_T6LD, C_T6ST, C_T7LD, C_T7ST, C_Z;

  function automatic logic [CTRL_W-1:0] mk(input int a, input int b = -1,
                                           input int c = -1, input int d = -1);
    logic [CTRL_W-1:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    if (d >= 0) r[d] = 1'b1;
    return r;
  endfunction

  function automatic vec_t row(input logic s, input logic mr, input logic [4:0] op,
                               input logic [3:0] st, input logic [CTRL_W-1:0] c,
                               input logic [3:0] f);
    vec_t v;
    v.start = s; v.mr = mr; v.op = op; v.e_step = st; v.e_ctrl = c; v.e_flags = f;
    return v;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_obs(input string name, input logic [3:0] e_step,
                           input logic [CTRL_W-1:0] e_ctrl, input logic [3:0] e_flags);
    logic [OBS_W-1:0] act, expv;
    exp_q.push_back({e_step, e_ctrl, e_flags});
    act  = {step, ctrl, busy, done, illegal, timeout};
    expv = exp_q.pop_front();
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got step=%0d ctrl=%h bdit=%b, expected step=%0d ctrl=%h bdit=%b",
               name, act[OBS_W-1 -: 4], act[CTRL_W+3:4], act[3:0],
               expv[OBS_W-1 -: 4], expv[CTRL_W+3:4], expv[3:0]);
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      start     = tbl[i].start;
      mem_ready = tbl[i].mr;
      ir_opcode = tbl[i].op;
      tick();
      check_obs($sformatf("%s[%0d]", tag, i), tbl[i].e_step, tbl[i].e_ctrl, tbl[i].e_flags);
    end
    tbl.delete();
    start = 1'b0;
  endtask

  initial begin
    C_Z    = '0;
    C_T0   = mk(CTRL_PCOUT, CTRL_MARIN, CTRL_INCPC, CTRL_ZIN);
    C_T1   = mk(CTRL_ZLOWOUT, CTRL_PCIN, CTRL_READ, CTRL_MDRIN);
    C_T2   = mk(CTRL_MDROUT, CTRL_IRIN);
    C_T3   = mk(CTRL_GRB, CTRL_BAOUT, CTRL_YIN);
    C_T4   = mk(CTRL_COUT, CTRL_ADD, CTRL_ZIN);
    C_T5LS = mk(CTRL_ZLOWOUT, CTRL_MARIN);
    C_T5I  = mk(CTRL_ZLOWOUT, CTRL_GRA, CTRL_RIN);
    C_T6LD = mk(CTRL_READ, CTRL_MDRIN);
    C_T6ST = mk(CTRL_GRA, CTRL_ROUT, CTRL_MDRIN);
    C_T7LD = mk(CTRL_MDROUT, CTRL_GRA, CTRL_RIN);
    C_T7ST = mk(CTRL_WRITE);

    // Reset with start also high: Clear must win.
    Clear = 1'b1; start = 1'b1; mem_ready = 1'b1; ir_opcode = LD_OP;
    tick();
    tick();
    check_obs("reset_clear_wins", 4'd0, C_Z, 4'b0000);
    Clear = 1'b0; start = 1'b0;
    tick();
    check_obs("reset_idle", 4'd0, C_Z, 4'b0000);

    // ld, zero wait; stray start pulses mid-instruction must not queue.
    tbl.push_back(row(1, 1, LD_OP, 4'd7,  C_T0,   F_B));
    tbl.push_back(row(0, 1, LD_OP, 4'd8,  C_T1,   F_B));
    tbl.push_back(row(0, 1, LD_OP, 4'd9,  C_T2,   F_B));
    tbl.push_back(row(0, 1, LD_OP, 4'd10, C_T3,   F_B));
    tbl.push_back(row(1, 1, LD_OP, 4'd11, C_T4,   F_B));
    tbl.push_back(row(0, 1, LD_OP, 4'd12, C_T5LS, F_B));
    tbl.push_back(row(0, 1, LD_OP, 4'd13, C_T6LD, F_B));
    tbl.push_back(row(0, 1, LD_OP, 4'd14, C_T7LD, F_B));
    tbl.push_back(row(1, 1, LD_OP, 4'd15, C_Z,    F_B | F_D));
    tbl.push_back(row(1, 1, LD_OP, 4'd0,  C_Z,    4'b0000));
    tbl.push_back(row(0, 1, LD_OP, 4'd0,  C_Z,    4'b0000));
    run_table("ld");

    // st: T6 does not wait; T7 holds Write for 4 cycles (3 not-ready).
    tbl.push_back(row(1, 1, ST_OP, 4'd7,  C_T0,   F_B));
    tbl.push_back(row(0, 1, ST_OP, 4'd8,  C_T1,   F_B));
    tbl.push_back(row(0, 1, ST_OP, 4'd9,  C_T2,   F_B));
    tbl.push_back(row(0, 1, ST_OP, 4'd10, C_T3,   F_B));
    tbl.push_back(row(0, 1, ST_OP, 4'd11, C_T4,   F_B));
    tbl.push_back(row(0, 1, ST_OP, 4'd12, C_T5LS, F_B));
    tbl.push_back(row(0, 1, ST_OP, 4'd13, C_T6ST, F_B));
    tbl.push_back(row(0, 0, ST_OP, 4'd14, C_T7ST, F_B));
    tbl.push_back(row(0, 0, ST_OP, 4'd14, C_T7ST, F_B));
    tbl.push_back(row(0, 0, ST_OP, 4'd14, C_T7ST, F_B));
    tbl.push_back(row(0, 0, ST_OP, 4'd14, C_T7ST, F_B));
    tbl.push_back(row(0, 1, ST_OP, 4'd15, C_Z,    F_B | F_D));
    tbl.push_back(row(0, 1, ST_OP, 4'd0,  C_Z,    4'b0000));
    run_table("st");

    // ldi: DONE in cycle 7.
    tbl.push_back(row(1, 1, LDI_OP, 4'd7,  C_T0,  F_B));
    tbl.push_back(row(0, 1, LDI_OP, 4'd8,  C_T1,  F_B));
    tbl.push_back(row(0, 1, LDI_OP, 4'd9,  C_T2,  F_B));
    tbl.push_back(row(0, 1, LDI_OP, 4'd10, C_T3,  F_B));
    tbl.push_back(row(0, 1, LDI_OP, 4'd11, C_T4,  F_B));
    tbl.push_back(row(0, 1, LDI_OP, 4'd12, C_T5I, F_B));
    tbl.push_back(row(0, 1, LDI_OP, 4'd15, C_Z,   F_B | F_D));
    tbl.push_back(row(0, 1, LDI_OP, 4'd0,  C_Z,   4'b0000));
    run_table("ldi");

    // Illegal opcode: quiet T3 with illegal pulse, then IDLE and no done.
    tbl.push_back(row(1, 1, BAD_OP, 4'd7,  C_T0, F_B));
    tbl.push_back(row(0, 1, BAD_OP, 4'd8,  C_T1, F_B));
    tbl.push_back(row(0, 1, BAD_OP, 4'd9,  C_T2, F_B));
    tbl.push_back(row(0, 1, BAD_OP, 4'd10, C_Z,  F_B | F_I));
    tbl.push_back(row(0, 1, BAD_OP, 4'd0,  C_Z,  4'b0000));
    tbl.push_back(row(0, 1, BAD_OP, 4'd0,  C_Z,  4'b0000));
    run_table("illegal");

    // Clear while ld is waiting in T6, then a clean restart.
    ir_opcode = LD_OP; mem_ready = 1'b1; start = 1'b1;
    tick();
    check_obs("clr_t0", 4'd7, C_T0, F_B);
    start = 1'b0;
    repeat (6) tick();
    check_obs("clr_t6", 4'd13, C_T6LD, F_B);
    mem_ready = 1'b0;
    tick();
    check_obs("clr_t6_hold", 4'd13, C_T6LD, F_B);
    Clear = 1'b1; start = 1'b1;
    tick();
    check_obs("clr_to_idle", 4'd0, C_Z, 4'b0000);
    Clear = 1'b0; mem_ready = 1'b1;
    tick();
    check_obs("restart_t0", 4'd7, C_T0, F_B);
    start = 1'b0;
    repeat (7) tick();
    check_obs("restart_t7", 4'd14, C_T7LD, F_B);
    tick();
    check_obs("restart_done", 4'd15, C_Z, F_B | F_D);
    tick();
    check_obs("restart_idle", 4'd0, C_Z, 4'b0000);

    // Memory never ready in T1.
    ir_opcode = LD_OP; mem_ready = 1'b1; start = 1'b1;
    tick();
    check_obs("stuck_t0", 4'd7, C_T0, F_B);
    start = 1'b0; mem_ready = 1'b0;
    tick();
    check_obs("stuck_t1", 4'd8, C_T1, F_B);
`ifdef MEM_TIMEOUT_EN
    repeat (14) tick();
    check_obs("stuck_pre_timeout", 4'd8, C_T1, F_B);
    tick();
    check_obs("stuck_timeout", 4'd8, C_Z, F_B | F_T);
    tick();
    check_obs("stuck_after_timeout", 4'd0, C_Z, 4'b0000);
`else
    repeat (100) tick();
    check_obs("stuck_hold_100", 4'd8, C_T1, F_B);
    mem_ready = 1'b1;
    tick();
    check_obs("stuck_release", 4'd9, C_T2, F_B);
    Clear = 1'b1;
    tick();
    check_obs("stuck_clear", 4'd0, C_Z, 4'b0000);
    Clear = 1'b0;
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, got no end of test, expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
